// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory arbiter: sizes, widths, port IDs
// and the address legality check used by the top level.
package data_mem_pkg;

  localparam int DEPTH_DEFAULT = 64;
  localparam int ERRW_DEFAULT  = 8;
  localparam int WORD_W        = 32;
  localparam int ADDR_W        = 32;

  localparam int PORT_LSU = 0;
  localparam int PORT_DBG = 1;

  // A word access is legal when it is word-aligned and its word index
  // falls inside the attached memory.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input int depth);
    logic [ADDR_W-1:0] word_idx;
    word_idx = {2'b00, addr[ADDR_W-1:2]};
    return (addr[1:0] == 2'b00) && (word_idx < ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester port of the data memory arbiter. The master modport is
// the requester side (LSU or debug/DMA); the slave modport is the arbiter.
interface data_mem_arbiter_if;
  import data_mem_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [WORD_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The grant is combinational from the
// requests and the registered identity of the most recently granted port.
module rr_arbiter2
  import data_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_gnt;

  // Pick a winner; on a conflict the port not served last wins, and
  // nothing is granted while reset is held.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == 1'(PORT_DBG)) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember who was granted last; reset favours the LSU on the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'(PORT_DBG);
    end else if (|gnt) begin
      last_gnt <= gnt[PORT_DBG];
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the core LSU and debug/DMA ports onto a single-ported data
// memory with combinational read, checks addresses, and returns a
// registered response one cycle after each grant.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int ERRW  = ERRW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  data_mem_arbiter_if.slave p0,
  data_mem_arbiter_if.slave p1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [WORD_W-1:0] mem_wd,
  input  logic [WORD_W-1:0] mem_rd,
  output logic [ERRW-1:0]   err_cnt
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              granted;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata;
  logic              legal;
  logic [WORD_W-1:0] rsp_data;
  logic              rsp_err;

  logic [1:0]        rvalid_q;
  logic [WORD_W-1:0] p0_rdata_q;
  logic [WORD_W-1:0] p1_rdata_q;
  logic              p0_err_q;
  logic              p1_err_q;

  assign req[PORT_LSU] = p0.req;
  assign req[PORT_DBG] = p1.req;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign granted = |gnt;
  assign p0.gnt  = gnt[PORT_LSU];
  assign p1.gnt  = gnt[PORT_DBG];

  // Route the granted port onto the memory bus; an idle bus is driven to zero.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[PORT_DBG]) begin
      sel_we    = p1.we;
      sel_addr  = p1.addr;
      sel_wdata = p1.wdata;
    end else if (gnt[PORT_LSU]) begin
      sel_we    = p0.we;
      sel_addr  = p0.addr;
      sel_wdata = p0.wdata;
    end
  end

  assign legal    = addr_legal(sel_addr, DEPTH);
  assign mem_a    = sel_addr;
  assign mem_wd   = sel_wdata;
  assign mem_we   = granted & sel_we & legal;
  assign rsp_data = (granted && legal && !sel_we) ? mem_rd : '0;
  assign rsp_err  = granted & ~legal;

  // Capture the response of this cycle's access for the granted port only;
  // reset discards any response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q   <= 2'b00;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
    end else begin
      rvalid_q   <= gnt;
      p0_rdata_q <= gnt[PORT_LSU] ? rsp_data : '0;
      p1_rdata_q <= gnt[PORT_DBG] ? rsp_data : '0;
      p0_err_q   <= gnt[PORT_LSU] & rsp_err;
      p1_err_q   <= gnt[PORT_DBG] & rsp_err;
    end
  end

  // Count errored accesses, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (rsp_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign p0.rvalid = rvalid_q[PORT_LSU];
  assign p1.rvalid = rvalid_q[PORT_DBG];
  assign p0.rdata  = p0_rdata_q;
  assign p1.rdata  = p1_rdata_q;
  assign p0.err    = p0_err_q;
  assign p1.err    = p1_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a behavioural data memory.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  localparam int DEPTH = 64;
  localparam int ERRW  = 8;

  logic              clk;
  logic              rst_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [WORD_W-1:0] mem_wd;
  logic [WORD_W-1:0] mem_rd;
  logic [ERRW-1:0]   err_cnt;

  int tests_run;
  int tests_failed;

  data_mem_arbiter_if p0_bus ();
  data_mem_arbiter_if p1_bus ();

  data_mem_arbiter #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .p0      (p0_bus),
    .p1      (p1_bus),
    .mem_we  (mem_we),
    .mem_a   (mem_a),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd),
    .err_cnt (err_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Data_Memory: combinational read, synchronous write
  logic [WORD_W-1:0] mem_model [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
  end
  assign mem_rd = (mem_a[31:2] < 30'(DEPTH)) ? mem_model[mem_a[7:2]] : '0;
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_a[7:2]] <= mem_wd;
  end

  task automatic idle_ports();
    p0_bus.req = 1'b0; p0_bus.we = 1'b0; p0_bus.addr = '0; p0_bus.wdata = '0;
    p1_bus.req = 1'b0; p1_bus.we = 1'b0; p1_bus.addr = '0; p1_bus.wdata = '0;
  endtask

  task automatic do_reset();
    idle_ports();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_ports();
    rst_n = 1'b0;
    p0_bus.req = 1'b1;
    p1_bus.req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (p0_bus.gnt !== 1'b0 || p1_bus.gnt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_gnt got %b%b expected 00", p1_bus.gnt, p0_bus.gnt);
    end
    tests_run++;
    if (p0_bus.rvalid !== 1'b0 || p1_bus.rvalid !== 1'b0 || p0_bus.err !== 1'b0 || p1_bus.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rsp got rvalid=%b%b err=%b%b expected 0", p1_bus.rvalid, p0_bus.rvalid, p1_bus.err, p0_bus.err);
    end
    tests_run++;
    if (p0_bus.rdata !== 32'h0 || p1_bus.rdata !== 32'h0 || err_cnt !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs got rdata0=%h rdata1=%h err_cnt=%h expected 0", p0_bus.rdata, p1_bus.rdata, err_cnt);
    end
    tests_run++;
    if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus got we=%b a=%h wd=%h expected 0", mem_we, mem_a, mem_wd);
    end
    idle_ports();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    p0_bus.req = 1'b1; p0_bus.we = 1'b1; p0_bus.addr = 32'h10; p0_bus.wdata = 32'hDEADBEEF;
    #1;
    tests_run++;
    if (p0_bus.gnt !== 1'b1 || p1_bus.gnt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wr_gnt got %b%b expected 01", p1_bus.gnt, p0_bus.gnt);
    end
    tests_run++;
    if (mem_we !== 1'b1 || mem_a !== 32'h10 || mem_wd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL wr_bus got we=%b a=%h wd=%h expected 1 00000010 deadbeef", mem_we, mem_a, mem_wd);
    end
    @(negedge clk);
    tests_run++;
    if (p0_bus.rvalid !== 1'b1 || p0_bus.err !== 1'b0 || p0_bus.rdata !== 32'h0 || p1_bus.rvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wr_rsp got rvalid=%b err=%b rdata=%h p1_rvalid=%b expected 1 0 0 0", p0_bus.rvalid, p0_bus.err, p0_bus.rdata, p1_bus.rvalid);
    end
    p0_bus.we = 1'b0; p0_bus.wdata = '0;
    #1;
    tests_run++;
    if (p0_bus.gnt !== 1'b1 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rd_gnt got gnt=%b we=%b expected 1 0", p0_bus.gnt, mem_we);
    end
    @(negedge clk);
    tests_run++;
    if (p0_bus.rvalid !== 1'b1 || p0_bus.rdata !== 32'hDEADBEEF || p0_bus.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rd_rsp got rvalid=%b rdata=%h err=%b expected 1 deadbeef 0", p0_bus.rvalid, p0_bus.rdata, p0_bus.err);
    end
    idle_ports();
    @(negedge clk);
    tests_run++;
    if (p0_bus.rvalid !== 1'b0 || p0_bus.rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL idle_rsp got rvalid=%b rdata=%h expected 0 0", p0_bus.rvalid, p0_bus.rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    do_reset();
    @(negedge clk);
    p0_bus.req = 1'b1; p0_bus.addr = 32'h10;
    p1_bus.req = 1'b1; p1_bus.addr = 32'h04;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(negedge clk);
        tests_run++;
        if ({p1_bus.rvalid, p0_bus.rvalid} !== exp_gnt[i-1]) begin
          tests_failed++;
          $display("[TB] FAIL rr_rvalid[%0d] got %b expected %b", i - 1, {p1_bus.rvalid, p0_bus.rvalid}, exp_gnt[i-1]);
        end
      end
      #1;
      tests_run++;
      if ({p1_bus.gnt, p0_bus.gnt} !== exp_gnt[i]) begin
        tests_failed++;
        $display("[TB] FAIL rr_gnt[%0d] got %b expected %b", i, {p1_bus.gnt, p0_bus.gnt}, exp_gnt[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if ({p1_bus.rvalid, p0_bus.rvalid} !== 2'b10 || p1_bus.rdata !== 32'h0 || p0_bus.rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL rr_last got rvalid=%b rdata1=%h rdata0=%h expected 10 0 0", {p1_bus.rvalid, p0_bus.rvalid}, p1_bus.rdata, p0_bus.rdata);
    end
    idle_ports();
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    p1_bus.req = 1'b1; p1_bus.we = 1'b1; p1_bus.addr = 32'h13; p1_bus.wdata = 32'h12345678;
    #1;
    tests_run++;
    if (p1_bus.gnt !== 1'b1 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mis_bus got gnt=%b we=%b expected 1 0", p1_bus.gnt, mem_we);
    end
    @(negedge clk);
    tests_run++;
    if (p1_bus.rvalid !== 1'b1 || p1_bus.err !== 1'b1 || p1_bus.rdata !== 32'h0 || err_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL mis_rsp got rvalid=%b err=%b rdata=%h err_cnt=%0d expected 1 1 0 1", p1_bus.rvalid, p1_bus.err, p1_bus.rdata, err_cnt);
    end
    idle_ports();
    p0_bus.req = 1'b1; p0_bus.addr = 32'h10;
    @(negedge clk);
    tests_run++;
    if (p0_bus.rvalid !== 1'b1 || p0_bus.rdata !== 32'hDEADBEEF || p0_bus.err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mis_readback got rvalid=%b rdata=%h err=%b expected 1 deadbeef 0", p0_bus.rvalid, p0_bus.rdata, p0_bus.err);
    end
    idle_ports();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    p0_bus.req = 1'b1; p0_bus.addr = 32'h100;
    #1;
    tests_run++;
    if (p0_bus.gnt !== 1'b1 || mem_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL oor_bus got gnt=%b we=%b expected 1 0", p0_bus.gnt, mem_we);
    end
    @(negedge clk);
    tests_run++;
    if (p0_bus.rvalid !== 1'b1 || p0_bus.err !== 1'b1 || p0_bus.rdata !== 32'h0 || err_cnt !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL oor_rsp got rvalid=%b err=%b rdata=%h err_cnt=%0d expected 1 1 0 2", p0_bus.rvalid, p0_bus.err, p0_bus.rdata, err_cnt);
    end
    // Back-to-back illegal accesses, one per cycle, push the counter past saturation
    for (int i = 0; i < 300; i++) @(negedge clk);
    tests_run++;
    if (err_cnt !== 8'hFF || p0_bus.rvalid !== 1'b1 || p0_bus.err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sat got err_cnt=%h rvalid=%b err=%b expected ff 1 1", err_cnt, p0_bus.rvalid, p0_bus.err);
    end
    idle_ports();
  endtask

  task automatic test_reset_drop();
    @(negedge clk);
    p1_bus.req = 1'b1; p1_bus.addr = 32'h10;
    #1;
    tests_run++;
    if (p1_bus.gnt !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drop_gnt got %b expected 1", p1_bus.gnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    p1_bus.req = 1'b0;
    #1;
    tests_run++;
    if (p1_bus.rvalid !== 1'b0 || p1_bus.rdata !== 32'h0 || err_cnt !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL drop_async got rvalid=%b rdata=%h err_cnt=%h expected 0 0 0", p1_bus.rvalid, p1_bus.rdata, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (p1_bus.rvalid !== 1'b0 || p0_bus.rvalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_after got rvalid=%b%b expected 00", p1_bus.rvalid, p0_bus.rvalid);
    end
    p0_bus.req = 1'b1; p0_bus.addr = 32'h10;
    p1_bus.req = 1'b1; p1_bus.addr = 32'h10;
    #1;
    tests_run++;
    if (p0_bus.gnt !== 1'b1 || p1_bus.gnt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_conflict got %b%b expected 01", p1_bus.gnt, p0_bus.gnt);
    end
    @(negedge clk);
    idle_ports();
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    idle_ports();
    test_reset();
    test_write_read();
    test_round_robin();
    test_misaligned();
    test_out_of_range();
    test_reset_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
